// File: rtl/top_main_sequencer.sv
// top_main_sequencer: issues a small program of packed instruction words onto the
// top_main input fields. It captures the response one cycle after each issue.
// Optional feature: define ZERO_SKIP_EN to make the all-ones opcode (SKZ) a local
// skip-if-zero instruction instead of an issued one.
module top_main_sequencer #(
    parameter int OPCODE_W   = 4,
    parameter int MEM_ADDR_W = 4,
    parameter int REG_ADDR_W = 3,
    parameter int DATA_W     = 8,
    parameter int DEPTH      = 16,
    parameter int PC_W       = $clog2(DEPTH),
    parameter int INSTR_W    = OPCODE_W + 2*MEM_ADDR_W + 2*REG_ADDR_W + DATA_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  prog_we,
    input  logic [PC_W-1:0]       prog_addr,
    input  logic [INSTR_W-1:0]    prog_wdata,
    input  logic [PC_W:0]         prog_len,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [OPCODE_W-1:0]   opcode,
    output logic [MEM_ADDR_W-1:0] read_address,
    output logic [MEM_ADDR_W-1:0] write_address,
    output logic [REG_ADDR_W-1:0] read_address_reg,
    output logic [REG_ADDR_W-1:0] write_address_reg,
    output logic [DATA_W-1:0]     data_in,
    input  logic [DATA_W-1:0]     data_out_mem,
    input  logic                  zero,
    output logic [DATA_W-1:0]     result_data,
    output logic                  result_zero,
    output logic                  result_valid,
    output logic [PC_W:0]         issue_count
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

    localparam logic [PC_W:0] DEPTH_L = (PC_W+1)'(DEPTH);
    localparam logic [PC_W:0] ONE     = (PC_W+1)'(1);
    localparam logic [PC_W:0] TWO     = (PC_W+1)'(2);

    logic [INSTR_W-1:0] mem_q [DEPTH];

    state_t             state_q, state_d;
    logic [PC_W:0]      pc_q, pc_d, len_q, len_d, cnt_q, cnt_d;
    logic [INSTR_W-1:0] fields_q, fields_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               rzero_q, rzero_d, rvalid_q, rvalid_d;
    logic               done_q, done_d, busy_q, busy_d;

    logic [INSTR_W-1:0] cur_w;
    logic [PC_W:0]      clamp_len;
    logic               skz;

    assign cur_w     = mem_q[pc_q[PC_W-1:0]];
    assign clamp_len = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;

`ifdef ZERO_SKIP_EN
    assign skz = (cur_w[INSTR_W-1 -: OPCODE_W] == {OPCODE_W{1'b1}});
`else
    assign skz = 1'b0;
`endif

    // Program memory: written only while idle, never cleared by reset
    always_ff @(posedge clk) begin
        if (prog_we && state_q == IDLE)
            mem_q[prog_addr] <= prog_wdata;
    end

    // Next-state and registered-output computation
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        fields_d = fields_q;
        rdata_d  = rdata_q;
        rzero_d  = rzero_q;
        rvalid_d = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d = clamp_len;
                    pc_d  = '0;
                    cnt_d = '0;
                    if (clamp_len == '0) done_d  = 1'b1;
                    else                 state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (skz) begin
                    // Skip-if-zero looks at the last captured flag, not the live input
                    pc_d = pc_q + (rzero_q ? TWO : ONE);
                    if (pc_d >= len_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    fields_d = cur_w;
                    cnt_d    = cnt_q + ONE;
                    state_d  = CAPTURE;
                end
            end
            CAPTURE: begin
                rdata_d  = data_out_mem;
                rzero_d  = zero;
                rvalid_d = 1'b1;
                pc_d     = pc_q + ONE;
                if (pc_q + ONE == len_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ISSUE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            fields_q <= '0;
            rdata_q  <= '0;
            rzero_q  <= 1'b0;
            rvalid_q <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            fields_q <= fields_d;
            rdata_q  <= rdata_d;
            rzero_q  <= rzero_d;
            rvalid_q <= rvalid_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign {opcode, read_address, write_address,
            read_address_reg, write_address_reg, data_in} = fields_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign result_data  = rdata_q;
    assign result_zero  = rzero_q;
    assign result_valid = rvalid_q;
    assign issue_count  = cnt_q;

endmodule

// File: tb/tb_top_main_sequencer.sv
// Randomized scoreboard bench for top_main_sequencer. A stand-in for top_main
// computes the response from the issued fields. A program-level model predicts
// which words are issued, their responses, and the cycle each result appears.
module tb_top_main_sequencer;

    localparam int DEPTH = 16;

`ifdef ZERO_SKIP_EN
    localparam bit SKZ_EN = 1'b1;
`else
    localparam bit SKZ_EN = 1'b0;
`endif

    typedef struct {
        int          cyc;
        logic [25:0] word;
        logic [7:0]  rd;
        logic        rz;
        int          cnt;
        logic        busy;
    } res_t;

    typedef struct {
        int cyc;
        int cnt;
    } done_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [25:0] prog_wdata;
    logic [4:0]  prog_len;
    logic        start;
    logic        busy, done;
    logic [3:0]  opcode, read_address, write_address;
    logic [2:0]  read_address_reg, write_address_reg;
    logic [7:0]  data_in, data_out_mem, result_data;
    logic        zero, result_zero, result_valid;
    logic [4:0]  issue_count;

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    res_t        rq[$];
    done_t       dq[$];
    logic [25:0] prog [DEPTH];
    logic        lastz = 1'b0;
    logic [25:0] last_word = '0;
    int          exp_cnt;
    int          s_cyc;

    top_main_sequencer dut (
        .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_wdata(prog_wdata), .prog_len(prog_len), .start(start),
        .busy(busy), .done(done), .opcode(opcode), .read_address(read_address),
        .write_address(write_address), .read_address_reg(read_address_reg),
        .write_address_reg(write_address_reg), .data_in(data_in),
        .data_out_mem(data_out_mem), .zero(zero), .result_data(result_data),
        .result_zero(result_zero), .result_valid(result_valid),
        .issue_count(issue_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in for top_main: a simple function of the presented fields
    assign data_out_mem = (data_in ^ {read_address, write_address}) + {4'h0, opcode};
    assign zero         = opcode[0] ^ data_in[0];

    function automatic logic [7:0] f_data(input logic [25:0] w);
        return (w[7:0] ^ w[21:14]) + {4'h0, w[25:22]};
    endfunction

    function automatic logic f_zero(input logic [25:0] w);
        return w[22] ^ w[0];
    endfunction

    function automatic logic [25:0] rand_word(input bit allow_skz);
        logic [25:0] w;
        w = 26'($urandom);
        if (SKZ_EN && !allow_skz && w[25:22] == 4'hF) w[25:22] = 4'h3;
        return w;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Program-level model: walk the words, predict issues, responses and timing
    task automatic model_push(input int plen, input int s);
        int len, t, i, cnt;
        logic [25:0] w;
        res_t e;
        done_t d;
        len = (plen > DEPTH) ? DEPTH : plen;
        t = s + 1;
        i = 0;
        cnt = 0;
        while (i < len) begin
            w = prog[i];
            if (SKZ_EN && w[25:22] == 4'hF) begin
                i += lastz ? 2 : 1;
                t += 1;
            end else begin
                cnt++;
                i++;
                e.cyc = t + 2; e.word = w; e.rd = f_data(w); e.rz = f_zero(w);
                e.cnt = cnt; e.busy = (i < len);
                rq.push_back(e);
                lastz = f_zero(w);
                last_word = w;
                t += 2;
            end
        end
        d.cyc = t; d.cnt = cnt;
        dq.push_back(d);
        exp_cnt = cnt;
    endtask

    task automatic load(input int a, input logic [25:0] w);
        @(negedge clk);
        prog_we = 1'b1; prog_addr = 4'(a); prog_wdata = w;
        prog[a] = w;
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    task automatic start_run(input int plen, input bit we, input int wa, input logic [25:0] wd);
        @(negedge clk);
        if (we) begin
            prog_we = 1'b1; prog_addr = 4'(wa); prog_wdata = wd;
            prog[wa] = wd;
        end
        prog_len = 5'(plen);
        start = 1'b1;
        s_cyc = cyc;
        model_push(plen, s_cyc);
        @(negedge clk);
        start = 1'b0;
        prog_we = 1'b0;
    endtask

    task automatic wait_run();
        for (int k = 0; k < 2*DEPTH + 12 && (rq.size() != 0 || dq.size() != 0); k++)
            @(negedge clk);
        chk("run_complete_pending", 32'(rq.size() + dq.size()), 32'd0);
        rq.delete();
        dq.delete();
        @(negedge clk);
    endtask

    task automatic run(input int plen);
        start_run(plen, 1'b0, 0, '0);
        wait_run();
    endtask

    // Monitor: every result_valid / done pulse must match the head of its queue
    always @(negedge clk) begin
        if (rst_n) begin
            if (result_valid) begin
                if (rq.size() == 0) chk("unexpected_result_valid", 32'd1, 32'd0);
                else begin
                    res_t e;
                    e = rq.pop_front();
                    chk("result_cycle", 32'(cyc), 32'(e.cyc));
                    chk("fields", {6'd0, opcode, read_address, write_address,
                                   read_address_reg, write_address_reg, data_in}, {6'd0, e.word});
                    chk("result_data", {24'd0, result_data}, {24'd0, e.rd});
                    chk("result_zero", {31'd0, result_zero}, {31'd0, e.rz});
                    chk("issue_count_at_result", {27'd0, issue_count}, 32'(e.cnt));
                    chk("busy_at_result", {31'd0, busy}, {31'd0, e.busy});
                end
            end
            if (done) begin
                if (dq.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
                else begin
                    done_t d;
                    d = dq.pop_front();
                    chk("done_cycle", 32'(cyc), 32'(d.cyc));
                    chk("issue_count_at_done", {27'd0, issue_count}, 32'(d.cnt));
                    chk("busy_at_done", {31'd0, busy}, 32'd0);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_wdata = '0;
        prog_len = '0; start = 1'b0;
        for (int i = 0; i < DEPTH; i++) prog[i] = '0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {busy, done, opcode, read_address, write_address,
                              read_address_reg, write_address_reg, data_in},
            32'd0);
        chk("reset_results", {18'd0, result_data, result_zero, result_valid, issue_count}, 32'd0);
        rst_n = 1'b1;
        // Program memory contents are unknown after power-up; fill every word
        for (int i = 0; i < DEPTH; i++) load(i, rand_word(1'b0));

        // Basic three-word run
        for (int i = 0; i < 3; i++) load(i, rand_word(1'b0));
        run(3);
        chk("three_word_count", {27'd0, issue_count}, 32'd3);

        // Zero-length run: only done, fields untouched
        run(0);
        chk("len0_opcode_held", {28'd0, opcode}, {28'd0, last_word[25:22]});
        chk("len0_issue_count", {27'd0, issue_count}, 32'd0);

        // Reset in the middle of a run, then restart
        for (int i = 0; i < 8; i++) load(i, rand_word(1'b0));
        start_run(8, 1'b0, 0, '0);
        while (cyc < s_cyc + 5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrun_reset_outputs", {busy, done, opcode, read_address, write_address,
                                     read_address_reg, write_address_reg, data_in}, 32'd0);
        chk("midrun_reset_results", {18'd0, result_data, result_zero, result_valid, issue_count}, 32'd0);
        rq.delete(); dq.delete();
        lastz = 1'b0; last_word = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        run(3);

        // Write and start on the same cycle: the new word must be the one issued
        start_run(2, 1'b1, 0, rand_word(1'b0));
        wait_run();

        // Over-long length clamps to the whole memory
        for (int i = 0; i < DEPTH; i++) load(i, rand_word(1'b0));
        run(20);
        chk("clamp_issue_count", {27'd0, issue_count}, 32'(exp_cnt));

        // start/prog_we while busy are ignored
        start_run(8, 1'b0, 0, '0);
        repeat (3) @(negedge clk);
        prog_we = 1'b1; prog_addr = 4'd7; prog_wdata = ~prog[7];
        start = 1'b1; prog_len = 5'd2;
        @(negedge clk);
        prog_we = 1'b0; start = 1'b0;
        wait_run();
        run(8);

        // Random programs and lengths
        for (int r = 0; r < 6; r++) begin
            int n;
            n = int'($urandom_range(0, DEPTH - 1));
            for (int i = 0; i <= n; i++) load(i, rand_word(1'b1));
            run(int'($urandom_range(0, 20)));
        end

`ifdef ZERO_SKIP_EN
        // Skip-if-zero: w1 sets zero, w2 is SKZ, w3 skipped, w4 issued
        load(0, {4'h2, 14'($urandom), 8'h00});
        load(1, {4'h2, 14'($urandom), 8'h01});
        load(2, {4'hF, 22'($urandom)});
        load(3, rand_word(1'b0));
        load(4, rand_word(1'b0));
        run(5);
        chk("skz_issue_count", {27'd0, issue_count}, 32'd3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
